// File: rtl/uart_wb_host_if.sv
// Register-port bus between the UART host initiator and the uart slave.
// The host drives strobe, phase clock, address, direction and write data.
interface uart_wb_host_if;
    logic [1:0] wb_addr;
    logic [7:0] wb_data_out;
    logic [7:0] wb_data_in;
    logic       wb_we;
    logic       wb_clk;
    logic       wb_stb;
    logic       wb_ack;

    modport master (
        output wb_addr, wb_data_out, wb_we, wb_clk, wb_stb,
        input  wb_data_in, wb_ack
    );

    modport slave (
        input  wb_addr, wb_data_out, wb_we, wb_clk, wb_stb,
        output wb_data_in, wb_ack
    );
endinterface

// File: rtl/uart_wb_host.sv
// Command/response front end that runs the four-phase stb/clk/ack
// handshake on the UART register port, with a per-phase ack timeout.
module uart_wb_host #(
    parameter int HOLD_CYCLES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [1:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       busy,
    uart_wb_host_if.master wb
);

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        HOLD,
        RELEASE
    } state_t;

    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [15:0] HOLD_INIT = 16'(HOLD_CYCLES - 1);

    state_t      state;
    logic [15:0] tmo_cnt;
    logic [15:0] hold_cnt;
    logic [1:0]  addr_q;
    logic [7:0]  data_q;
    logic        we_q;
    logic        stb_q;
    logic        clk_q;

    assign wb.wb_addr     = addr_q;
    assign wb.wb_data_out = data_q;
    assign wb.wb_we       = we_q;
    assign wb.wb_stb      = stb_q;
    assign wb.wb_clk      = clk_q;

    // A stuck-high ack from a previous aborted cycle blocks new commands.
    assign cmd_ready = (state == IDLE) && !wb.wb_ack;

    // Handshake sequencer with registered bus and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            hold_cnt  <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            stb_q     <= 1'b0;
            clk_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        addr_q  <= cmd_addr;
                        data_q  <= cmd_data;
                        we_q    <= ~cmd_write;
                        stb_q   <= 1'b1;
                        clk_q   <= 1'b1;
                        tmo_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= STROBE;
                    end
                end
                STROBE: begin
                    if (wb.wb_ack) begin
                        // The ack cycle itself is the first hold cycle.
                        if (HOLD_CYCLES <= 1) begin
                            clk_q   <= 1'b0;
                            tmo_cnt <= '0;
                            state   <= RELEASE;
                        end else begin
                            hold_cnt <= HOLD_INIT;
                            state    <= HOLD;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        stb_q     <= 1'b0;
                        clk_q     <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                HOLD: begin
                    if (hold_cnt <= 16'd1) begin
                        clk_q   <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt - 16'd1;
                    end
                end
                RELEASE: begin
                    if (!wb.wb_ack) begin
                        stb_q     <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_data  <= we_q ? wb.wb_data_in : 8'h00;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        stb_q     <= 1'b0;
                        clk_q     <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_wb_host.sv
// Bench for uart_wb_host: slave model on the bus, a scoreboard of
// expected responses and a monitor that checks them as they appear.
module tb_uart_wb_host;
    localparam int H   = 2;
    localparam int TMO = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [1:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       busy;

    uart_wb_host_if bus ();

    uart_wb_host #(
        .HOLD_CYCLES(H),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_data(cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .busy(busy),
        .wb(bus.master)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: mode 0 compliant, 1 never acks, 2 ack never drops.
    int         mode = 0;
    logic       ack = 1'b0;
    logic [7:0] sdata = 8'h00;
    logic [7:0] smem [4];
    logic [7:0] seed [4];

    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 4; i++) smem[i] <= seed[i];
        end
        if (ack) sdata <= 8'($urandom);
        if (mode != 1 && bus.wb_stb && bus.wb_clk && !ack) begin
            ack <= 1'b1;
            if (!bus.wb_we) smem[bus.wb_addr] <= bus.wb_data_out;
        end else if (mode != 2 && ack && !bus.wb_clk) begin
            ack   <= 1'b0;
            sdata <= smem[bus.wb_addr];
        end
    end

    assign bus.wb_ack     = ack;
    assign bus.wb_data_in = sdata;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         due;
        logic [1:0] addr;
        logic       we;
        logic [7:0] wdata;
    } exp_t;

    exp_t       q[$];
    logic [7:0] mmem [4];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Monitor: bus setup on each new strobe, responses against queue.
    initial begin
        logic stb_p;
        exp_t e;
        stb_p = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.wb_stb && !stb_p) begin
                    if (q.size() == 0) begin
                        check("stb_unexpected", bus.wb_stb, 0);
                    end else begin
                        check("wb_addr", bus.wb_addr, q[0].addr);
                        check("wb_we", bus.wb_we, q[0].we);
                        check("wb_data_out", bus.wb_data_out, q[0].wdata);
                    end
                end
                if (rsp_valid) begin
                    if (q.size() == 0) begin
                        check("rsp_unexpected", rsp_valid, 0);
                    end else begin
                        e = q.pop_front();
                        check("rsp_data", rsp_data, e.data);
                        check("rsp_err", rsp_err, e.err);
                        check("rsp_cycle", cyc, e.due);
                        if (e.err)
                            check("tmo_bus_low",
                                  {bus.wb_stb, bus.wb_clk}, 0);
                    end
                end
            end
            stb_p = bus.wb_stb;
        end
    end

    // kind: 0 compliant slave, 1 no ack, 2 ack stuck high.
    task automatic issue(input logic w, input logic [1:0] a,
                         input logic [7:0] d, input int kind,
                         output int acc);
        exp_t e;
        int   n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_data  = d;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", cmd_ready, 1);
            cmd_valid = 1'b0;
            acc = -1;
            return;
        end
        acc     = cyc;
        e.we    = ~w;
        e.addr  = a;
        e.wdata = d;
        e.err   = (kind != 0);
        e.data  = 8'h00;
        if (kind == 0) begin
            e.due = acc + H + 4;
            if (!w) e.data = mmem[a];
        end else if (kind == 1) begin
            e.due = acc + TMO + 1;
        end else begin
            e.due = acc + H + 2 + TMO;
        end
        if (w && kind != 1) mmem[a] = d;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("drain_busy", busy, 0);
            check("drain_queue", q.size(), 0);
        end
        @(negedge clk);
    endtask

    initial begin
        int acc;
        int a1;
        int a2;
        int hc;
        int n;
        seed[0] = 8'h10;
        seed[1] = 8'hA3;
        seed[2] = 8'h20;
        seed[3] = 8'h5C;
        for (int i = 0; i < 4; i++) mmem[i] = seed[i];

        repeat (3) @(negedge clk);
        check("reset_outputs",
              {bus.wb_stb, bus.wb_clk, bus.wb_we, bus.wb_addr,
               bus.wb_data_out, rsp_valid, rsp_err, rsp_data}, 0);
        check("reset_busy", busy, 0);
        check("reset_ready", cmd_ready, 1);
        reset = 1'b0;
        @(negedge clk);

        // Write TX and count phase-clock high cycles.
        issue(1'b1, 2'd0, 8'h55, 0, acc);
        cmd_valid = 1'b0;
        hc = 0;
        repeat (8) begin
            if (bus.wb_clk) hc++;
            @(negedge clk);
        end
        check("clk_high_cycles", hc, H + 1);
        drain();

        // Read RX.
        issue(1'b0, 2'd1, 8'h00, 0, acc);
        cmd_valid = 1'b0;
        drain();

        // Back-to-back with valid held high.
        issue(1'b1, 2'd2, 8'h4E, 0, a1);
        issue(1'b0, 2'd1, 8'h00, 0, a2);
        cmd_valid = 1'b0;
        check("b2b_accept", a2, a1 + H + 4);
        drain();

        // Timeout in STROBE.
        mode = 1;
        issue(1'b1, 2'd3, 8'h99, 1, acc);
        cmd_valid = 1'b0;
        drain();
        mode = 0;

        // Timeout in RELEASE, then ack stays high.
        mode = 2;
        issue(1'b0, 2'd1, 8'h00, 2, acc);
        cmd_valid = 1'b0;
        drain();
        repeat (4) begin
            check("stuck_ready", cmd_ready, 0);
            @(negedge clk);
        end
        mode = 0;
        n = 0;
        while (!cmd_ready && n < 5) begin
            @(negedge clk);
            n++;
        end
        check("ready_after_drop", cmd_ready, 1);

        // Reset while in HOLD.
        issue(1'b1, 2'd3, 8'h3C, 0, acc);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        q.delete();
        check("midreset_outputs",
              {bus.wb_stb, bus.wb_clk, bus.wb_we, bus.wb_addr,
               bus.wb_data_out, rsp_valid, rsp_err, rsp_data}, 0);
        check("midreset_busy", busy, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        issue(1'b1, 2'd0, 8'h77, 0, acc);
        cmd_valid = 1'b0;
        drain();
        issue(1'b0, 2'd3, 8'h00, 0, acc);
        cmd_valid = 1'b0;
        drain();

        // Random traffic with random gaps and back-to-back runs.
        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  8'($urandom), 0, acc);
            if ($urandom_range(0, 2) != 0) begin
                cmd_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        cmd_valid = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
